// File: rtl/sm4_pkg.sv
// Shared SM4 constants and helpers: FK system parameters, CK generation, the key-schedule
// linear transform L' and the byte S-box table used by both key expansion and the crypt datapath.
package sm4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_XOR,
        ST_SBOX,
        ST_MIX,
        ST_DONE
    } sm4_kexp_state_e;

    localparam logic [31:0] FK [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

    // Entry 0 is the leftmost byte, so the table reads row by row like the published S-box.
    localparam logic [0:255][7:0] SBOX_TABLE = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    // CK[i] byte j is ((4i+j)*7) mod 256, byte 0 in the most significant position.
    function automatic logic [31:0] sm4Ck(input logic [4:0] idx);
        logic [7:0]  base;
        logic [7:0]  term;
        logic [31:0] ck;
        base = {1'b0, idx, 2'b00};
        ck   = '0;
        for (int j = 0; j < 4; j++) begin
            term              = base + 8'(j);
            ck[31-8*j -: 8]   = term * 8'd7;
        end
        return ck;
    endfunction

    function automatic logic [31:0] sm4LKey(input logic [31:0] b);
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

endpackage

// File: rtl/sm4_key_expand_if.sv
// Key-load handshake and round-key read port between the key schedule and its users.
interface sm4_key_expand_if;
    logic [127:0] i_key;
    logic         i_key_valid;
    logic         o_key_ready;
    logic         o_busy;
    logic         o_done;
    logic         o_keys_valid;
    logic [4:0]   i_rk_idx;
    logic         i_decrypt;
    logic [31:0]  o_rk;

    modport master (
        output i_key, i_key_valid, i_rk_idx, i_decrypt,
        input  o_key_ready, o_busy, o_done, o_keys_valid, o_rk
    );

    modport slave (
        input  i_key, i_key_valid, i_rk_idx, i_decrypt,
        output o_key_ready, o_busy, o_done, o_keys_valid, o_rk
    );
endinterface

// File: rtl/S_Box.sv
// SM4 byte substitution with one registered cycle of latency and a travelling valid flag.
module S_Box
    import sm4_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       valid_o,
    output logic [7:0] data_o
);

    logic       valid_q;
    logic [7:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_i;
            data_q  <= SBOX_TABLE[data_i];
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/sm4_key_expand.sv
// SM4 key schedule: expands a 128-bit master key into 32 round keys, one round per
// XOR/SBOX/MIX pass, and serves them from a 32-entry store with a registered read port.
module sm4_key_expand
    import sm4_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    sm4_key_expand_if.slave bus
);

    sm4_kexp_state_e state_q;
    logic [4:0]      ctr_q;
    logic [31:0]     k_q [4];
    logic [31:0]     a_q;
    logic            sboxVld_q;
    logic            ready_q;
    logic            busy_q;
    logic            done_q;
    logic            keysValid_q;
    logic [31:0]     rk_q;
    logic [31:0]     store_q [32];

    logic [3:0]      sbVld;
    logic [31:0]     bWord;
    logic [31:0]     mixRk_d;
    logic            mixGo;
    logic [4:0]      rdIdx;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        S_Box u_sbox (
            .clk_i   (i_clk),
            .rst_i   (i_rst),
            .valid_i (sboxVld_q),
            .data_i  (a_q[31-8*g -: 8]),
            .valid_o (sbVld[g]),
            .data_o  (bWord[31-8*g -: 8])
        );
    end

    assign mixRk_d = k_q[0] ^ sm4LKey(bWord);
    assign mixGo   = (state_q == ST_MIX) && (&sbVld);

    // Status outputs are registered alongside the state so they change on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            ctr_q       <= '0;
            k_q         <= '{default: '0};
            a_q         <= '0;
            sboxVld_q   <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            keysValid_q <= 1'b0;
        end else begin
            sboxVld_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_key_valid) begin
                        for (int i = 0; i < 4; i++) begin
                            k_q[i] <= bus.i_key[127-32*i -: 32] ^ FK[i];
                        end
                        ctr_q       <= '0;
                        keysValid_q <= 1'b0;
                        ready_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_XOR;
                    end
                end
                ST_XOR: begin
                    a_q       <= k_q[1] ^ k_q[2] ^ k_q[3] ^ sm4Ck(ctr_q);
                    sboxVld_q <= 1'b1;
                    state_q   <= ST_SBOX;
                end
                ST_SBOX: begin
                    state_q <= ST_MIX;
                end
                ST_MIX: begin
                    if (mixGo) begin
                        k_q <= '{k_q[1], k_q[2], k_q[3], mixRk_d};
                        if (ctr_q == 5'd31) begin
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            keysValid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            ctr_q   <= ctr_q + 5'd1;
                            state_q <= ST_XOR;
                        end
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The store is deliberately left out of reset; o_keys_valid is what marks it trustworthy.
    always_ff @(posedge i_clk) begin
        if (mixGo) begin
            store_q[ctr_q] <= mixRk_d;
        end
    end

    assign rdIdx = bus.i_rk_idx ^ {5{bus.i_decrypt}};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rk_q <= '0;
        end else begin
            rk_q <= store_q[rdIdx];
        end
    end

    assign bus.o_key_ready  = ready_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;
    assign bus.o_keys_valid = keysValid_q;
    assign bus.o_rk         = rk_q;

endmodule

// File: tb/tb_sm4_key_expand.sv
// Self-checking bench for sm4_key_expand: golden vector, ignored loads, mid-run reset,
// back-to-back loads and random keys swept against a behavioural key-schedule model.
module tb_sm4_key_expand;

    logic clk = 1'b0;
    logic rst;
    int   checkCount = 0;
    int   errorCount = 0;
    int   n;
    logic [31:0]  refRk [32];
    logic [127:0] keyA;
    logic [127:0] keyB;

    localparam logic [127:0] GOLDEN_MK = 128'h0123456789ABCDEFFEDCBA9876543210;
    // o_done fills cycle T+97, i.e. it is visible right after the 96th edge following acceptance.
    localparam int DONE_EDGES = 97 - 1;

    sm4_key_expand_if busIf ();

    sm4_key_expand dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (busIf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [31:0] refCk(input int i);
        logic [31:0] c;
        c = '0;
        for (int j = 0; j < 4; j++) begin
            c = {c[23:0], 8'(((4 * i + j) * 7) % 256)};
        end
        return c;
    endfunction

    // Textbook key schedule: K[i+4] = K[i] ^ L'(tau(K[i+1]^K[i+2]^K[i+3]^CK[i])), rk[i] = K[i+4].
    task automatic buildReference(input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] fk [4];
        logic [31:0] t;
        logic [31:0] b;
        fk = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
        for (int i = 0; i < 4; i++) begin
            k[i] = mk[127-32*i -: 32] ^ fk[i];
        end
        for (int i = 0; i < 32; i++) begin
            t = k[i+1] ^ k[i+2] ^ k[i+3] ^ refCk(i);
            b = {sm4_pkg::SBOX_TABLE[t[31:24]], sm4_pkg::SBOX_TABLE[t[23:16]],
                 sm4_pkg::SBOX_TABLE[t[15:8]],  sm4_pkg::SBOX_TABLE[t[7:0]]};
            k[i+4]   = k[i] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
            refRk[i] = k[i+4];
        end
    endtask

    task automatic applyStimulus(input logic [127:0] key, input bit hold);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!busIf.o_key_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("load_wait_ready", 32'(busIf.o_key_ready), 32'd1);
        busIf.i_key       = key;
        busIf.i_key_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) busIf.i_key_valid = 1'b0;
        checkOutput("accept_busy", 32'(busIf.o_busy), 32'd1);
        checkOutput("accept_ready", 32'(busIf.o_key_ready), 32'd0);
        checkOutput("accept_keys_valid", 32'(busIf.o_keys_valid), 32'd0);
    endtask

    task automatic waitDone(input int start, output int edges);
        edges = start;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!busIf.o_done && edges < 300);
    endtask

    task automatic readKey(input int idx, input bit dec, input logic [31:0] expected, input string tag);
        @(negedge clk);
        busIf.i_rk_idx  = 5'(idx);
        busIf.i_decrypt = dec;
        @(negedge clk);
        checkOutput(tag, busIf.o_rk, expected);
    endtask

    task automatic sweepKeys();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) begin
                readKey(i, d[0], refRk[(d == 1) ? 31 - i : i],
                        $sformatf("%s[%0d]", (d == 1) ? "rk_dec" : "rk_enc", i));
            end
        end
    endtask

    task automatic finishLoad(input int start, input string tag);
        waitDone(start, n);
        checkOutput({tag, "_latency"}, 32'(n), 32'(DONE_EDGES));
        checkOutput({tag, "_keys_valid"}, 32'(busIf.o_keys_valid), 32'd1);
        checkOutput({tag, "_busy_low"}, 32'(busIf.o_busy), 32'd0);
    endtask

    initial begin
        rst                = 1'b1;
        busIf.i_key        = '0;
        busIf.i_key_valid  = 1'b0;
        busIf.i_rk_idx     = '0;
        busIf.i_decrypt    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busIf.o_busy), 32'd0);
        checkOutput("rst_done", 32'(busIf.o_done), 32'd0);
        checkOutput("rst_keys_valid", 32'(busIf.o_keys_valid), 32'd0);
        checkOutput("rst_rk", busIf.o_rk, 32'd0);
        checkOutput("rst_ready", 32'(busIf.o_key_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Golden vector.
        buildReference(GOLDEN_MK);
        applyStimulus(GOLDEN_MK, 1'b0);
        finishLoad(0, "golden");
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", 32'(busIf.o_done), 32'd0);
        checkOutput("idle_ready", 32'(busIf.o_key_ready), 32'd1);
        checkOutput("idle_keys_valid", 32'(busIf.o_keys_valid), 32'd1);
        readKey(0, 1'b0, 32'hF12186F9, "gold_rk0");
        readKey(1, 1'b0, 32'h41662B61, "gold_rk1");
        readKey(31, 1'b0, 32'h9124A012, "gold_rk31");
        readKey(0, 1'b1, 32'h9124A012, "gold_dec_idx0");
        readKey(31, 1'b1, 32'hF12186F9, "gold_dec_idx31");
        sweepKeys();

        // A second load request in the middle of expansion must be dropped.
        applyStimulus(GOLDEN_MK, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("mid_busy", 32'(busIf.o_busy), 32'd1);
        checkOutput("mid_ready", 32'(busIf.o_key_ready), 32'd0);
        busIf.i_key       = ~GOLDEN_MK;
        busIf.i_key_valid = 1'b1;
        @(posedge clk);
        #1;
        busIf.i_key_valid = 1'b0;
        finishLoad(41, "ignored");
        readKey(0, 1'b0, 32'hF12186F9, "ignored_rk0");
        readKey(31, 1'b0, 32'h9124A012, "ignored_rk31");

        // Reset partway through aborts the run; a fresh load then completes normally.
        keyA = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(keyA, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_keys_valid", 32'(busIf.o_keys_valid), 32'd0);
        checkOutput("abort_ready", 32'(busIf.o_key_ready), 32'd1);
        checkOutput("abort_busy", 32'(busIf.o_busy), 32'd0);
        checkOutput("abort_rk", busIf.o_rk, 32'd0);
        keyB = {$urandom, $urandom, $urandom, $urandom};
        buildReference(keyB);
        applyStimulus(keyB, 1'b0);
        finishLoad(0, "after_abort");
        sweepKeys();

        // Back-to-back loads with i_key_valid held high.
        keyA = {$urandom, $urandom, $urandom, $urandom};
        keyB = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(keyA, 1'b1);
        finishLoad(0, "b2b_first");
        busIf.i_key = keyB;
        buildReference(keyB);
        @(posedge clk);
        #1;
        checkOutput("b2b_idle_ready", 32'(busIf.o_key_ready), 32'd1);
        checkOutput("b2b_idle_keys_valid", 32'(busIf.o_keys_valid), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("b2b_accept_busy", 32'(busIf.o_busy), 32'd1);
        checkOutput("b2b_accept_keys_valid", 32'(busIf.o_keys_valid), 32'd0);
        finishLoad(0, "b2b_second");
        busIf.i_key_valid = 1'b0;
        sweepKeys();

        // Further random keys.
        for (int r = 0; r < 2; r++) begin
            keyA = {$urandom, $urandom, $urandom, $urandom};
            buildReference(keyA);
            applyStimulus(keyA, 1'b0);
            finishLoad(0, $sformatf("rand%0d", r));
            sweepKeys();
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sm4_key_expand.md
SM4_KEY_EXPAND -- requirements
Module: sm4_key_expand

Interface
REQ-001 i_clk  input  1  single clock; all state updates on rising edge.
REQ-002 i_rst  input  1  reset, synchronous, active-high.
REQ-003 i_key  input  128  master key MK, MK0 in [127:96].
REQ-004 i_key_valid  input  1  load request; sampled only in IDLE.
REQ-005 o_key_ready  output  1  high while FSM in IDLE.
REQ-006 o_busy  output  1  high while FSM in XOR, SBOX or MIX.
REQ-007 o_done  output  1  one-cycle pulse when all 32 round keys are stored.
REQ-008 o_keys_valid  output  1  high from o_done until the next accepted load or reset.
REQ-009 i_rk_idx  input  5  round index requested by the round-function datapath.
REQ-010 i_decrypt  input  1  0 = rk[idx], 1 = rk[31-idx].
REQ-011 o_rk  output  32  registered round key for the requested index.

Function
REQ-012 FSM states SHALL be IDLE, XOR, SBOX, MIX, DONE; one-hot or binary is free.
REQ-013 IDLE with i_key_valid=1 SHALL load K0..K3 = MK0..MK3 XOR FK0..FK3, clear round counter, and go to XOR.
REQ-014 XOR SHALL register A = K1^K2^K3^CK[ctr], assert S-box valid, and go to SBOX.
REQ-015 SBOX SHALL wait exactly one cycle for the four 1-cycle-latency byte S-boxes; next state MIX.
REQ-016 MIX SHALL compute rk = K0 ^ B ^ (B<<<13) ^ (B<<<23), with B the S-box output word.
REQ-017 MIX SHALL write rk into store entry ctr and shift K to {K1,K2,K3,rk}.
REQ-018 MIX SHALL go to XOR with ctr+1 when ctr<31, and to DONE when ctr==31.
REQ-019 DONE SHALL last one cycle, assert o_done, set o_keys_valid, and return to IDLE.
REQ-020 Latency: load accepted at edge T gives o_done high during cycle T+97 (32 rounds x 3 cycles plus DONE).
REQ-021 CK[i] byte j SHALL equal ((4i+j)*7) mod 256; byte j=0 is the MSB.
REQ-022 A load SHALL clear o_keys_valid on the accepting edge.
REQ-023 i_key_valid outside IDLE SHALL be ignored, with no queuing.
REQ-024 o_rk SHALL update every cycle with a 1-cycle read latency, independent of FSM state.
REQ-025 When i_decrypt=1, the index SHALL be 31-i_rk_idx, computed as 5-bit wrap (bitwise invert).
REQ-026 Reads of entries during expansion SHALL return current store contents; consumers SHALL gate on o_keys_valid.
REQ-027 Store write and read of the same entry in one cycle SHALL return the old value.

Reset
REQ-028 While i_rst is high: FSM SHALL go to IDLE and o_busy, o_done, o_keys_valid, o_rk SHALL be 0.
REQ-029 While i_rst is high: the counter, K registers and A SHALL be 0; o_key_ready SHALL be 1 from the first cycle after reset.
REQ-030 Reset mid-expansion SHALL abort the expansion; the key store itself is not reset.
REQ-031 The reset value of the key store SHALL NOT be relied upon; o_keys_valid=0 marks it invalid.

Structure
REQ-032 The FK constants and the CK generation function/table SHALL live in shared package sm4_pkg, reused by the crypt datapath.
REQ-033 The L' linear transform (rotations 13/23) SHALL be a package function.
REQ-034 The block SHALL instantiate four copies of the existing S_Box sub-module (8-bit, 1-cycle registered, valid in/out); no new sub-module.
REQ-035 The key store SHALL be a 32x32 register array or distributed RAM with synchronous write and registered read.

Verification
REQ-036 Load MK=0123456789ABCDEFFEDCBA9876543210 -> o_done at T+97; rk[0]=F12186F9, rk[1]=41662B61, rk[31]=9124A012.
REQ-037 After REQ-036, i_decrypt=1 with idx=0 -> o_rk=9124A012 next cycle; idx=31 -> F12186F9.
REQ-038 Pulse i_key_valid with a different key at cycle T+40 -> ignored; final keys match REQ-036 values.
REQ-039 Assert i_rst at T+50 for 1 cycle -> o_keys_valid=0, o_key_ready=1 next cycle; a new load then completes normally in 97 cycles.
REQ-040 Back-to-back loads (i_key_valid held high) -> second load accepted in the IDLE cycle after DONE; o_keys_valid falls on acceptance and rises at the second o_done.
REQ-041 Sweep i_rk_idx 0..31 each cycle after done -> o_rk matches the golden model one cycle later for both i_decrypt values.
